maze_port_arbiter: RTL
======================

# maze_port_arbiter

Round-robin arbiter that shares the single-port maze memory (row/col address, output enable, write enable, 1-bit read data) between NPORTS requesters, such as the maze solver, a maze loader and a debug/visualisation reader. It sits between the requesters and the memory. It issues at most one memory access per cycle with registered address and strobes, and routes read data back to the requester that issued the read.

## Interface
- NPORTS, 2: number of requesters; legal range 2..4.
- ADDR_W, 6: width of row and of col.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NPORTS  request per port; level, held until granted.
- req_row  in  NPORTS*ADDR_W  row per port; port k occupies bits [k*ADDR_W +: ADDR_W].
- req_col  in  NPORTS*ADDR_W  column per port; same packing as req_row.
- req_oe  in  NPORTS  read request qualifier per port.
- req_we  in  NPORTS  write request qualifier per port.
- gnt  out  NPORTS  one-cycle grant pulse; one-hot or zero.
- rvalid  out  NPORTS  one-cycle read-data-valid pulse; one-hot or zero.
- rdata  out  1  read data; equals maze_in; meaningful only while some rvalid bit is high.
- row, col  out  ADDR_W  memory address, registered.
- maze_oe, maze_we  out  1  memory strobes, registered; never both high.
- maze_in  in  1  memory read data, valid the cycle after maze_oe.

## Operation
- Arbitration
  - Every rising edge, the arbiter evaluates the eligible ports: req[k]=1 and gnt[k]=0.
  - A port is never eligible in its own grant cycle. A held req after a grant therefore counts as a new request only from the next evaluation.
  - Round-robin pointer `last`, width clog2(NPORTS). Search order is last+1, last+2, … modulo NPORTS. The first eligible port wins, and `last` becomes the winner.
  - If no port is eligible, `last` is unchanged and gnt, maze_oe and maze_we go to 0.
- Issue, registered at the same edge as the grant
  - gnt[w]=1.
  - row and col take the winner's req_row and req_col.
  - Strobes are set by the winner's qualifiers:
    - req_we=1: maze_we=1, maze_oe=0. Write wins over read.
    - req_oe=1 and req_we=0: maze_oe=1.
    - Both qualifiers 0: no-op; granted, but both strobes stay 0 and no rvalid follows.
- Read return
  - Pending-read register: a valid bit plus a port index, loaded whenever maze_oe is issued.
  - In the following cycle, rvalid[index]=1 and rdata=maze_in.
  - Reads to different ports may be back-to-back. The pending register is overwritten every cycle.
- Hold values
  - row and col keep their last value when nothing is issued.
  - Strobes, gnt and rvalid are single-cycle pulses.
- Reset (rst_n low, asynchronous, any time)
  - gnt, rvalid, maze_oe and maze_we go to 0. row, col and rdata-qualifying state go to 0. Pending read is cleared.
  - last is set to NPORTS-1, so port 0 has first priority after reset.
  - A read in flight at reset produces no rvalid.
  - A grant whose strobe cycle is cut by reset is lost. The requester must re-request.

## Timing
- Edge E0 samples req[k]=1. Cycle C1 (after E0): gnt[k], row/col and strobe are valid. Cycle C2: rvalid[k] and rdata are valid for a read.
- Request-to-grant latency:
  - 1 cycle when uncontended.
  - At most NPORTS cycles under full contention (starvation-free).
- Throughput:
  - One memory access per cycle aggregate.
  - At most one grant every 2 cycles to a single port, because of grant-cycle ineligibility.
- The requester must keep req_row, req_col, req_oe and req_we stable while req=1 and gnt=0. It may change them in its gnt cycle.
- There is no combinational path from req to any output. rdata is combinational from maze_in.

## Test plan
- Single read: port0 requests row=5, col=7, oe=1, all others idle → next cycle gnt=0001, row=5, col=7, maze_oe=1. Following cycle rvalid=0001, rdata=maze_in.
- Contention: ports 0 and 1 hold req continuously with oe=1 and NPORTS=2 → grants alternate 01,10,01,10. A memory strobe appears every cycle, and each rvalid matches the port granted one cycle earlier.
- Write precedence and no-op:
  - Port1 with oe=1, we=1 → maze_we=1, maze_oe=0, no rvalid.
  - Port1 with oe=0, we=0 → gnt=10, no strobes, no rvalid.
- Lone continuous requester: port2 holds req for 6 cycles, NPORTS=4, others idle → gnt[2] on cycles 1, 3, 5. Strobes appear only in those cycles.
- Round-robin order: all 4 ports request from reset → grant order 0,1,2,3,0. After port2 drops req, the order skips port 2.
- Reset mid-read: pull rst_n low in the cycle maze_oe=1 → all outputs 0 immediately. No rvalid after release, and the first post-reset grant goes to port 0 when ports 0 and 3 both request.

Source files
------------

// File: rtl/maze_port_arbiter.sv
// -----------------------------------------------------------------------------
// maze_port_arbiter
//
// Round-robin arbiter that shares the single-port maze memory between NPORTS
// requesters (solver, loader, debug reader, ...). At most one memory access
// is issued per cycle. Address and strobes are registered. Read data is
// routed back to the port that issued the read, one cycle after maze_oe.
//
// Handshake: a requester raises req[k] and holds it, together with
// req_row/req_col/req_oe/req_we, until it sees gnt[k]. gnt[k] is a one-cycle
// pulse that marks the cycle in which the access is on the memory bus. A read
// returns rvalid[k] in the cycle after gnt[k], with rdata valid in that cycle.
// A port is never eligible in its own grant cycle, so a held req is treated as
// a new request only from the following evaluation.
//
// Parameters
//   NPORTS  number of requesters (2..4)
//   ADDR_W  width of row and of col
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 per-port request level
//   req_row, req_col    per-port address; port k at [k*ADDR_W +: ADDR_W]
//   req_oe, req_we      per-port read / write qualifiers (write wins)
//   gnt                 one-hot grant pulse (or zero)
//   rvalid              one-hot read-data-valid pulse (or zero)
//   rdata               read data, straight from maze_in
//   row, col            registered memory address
//   maze_oe, maze_we    registered memory strobes, never both high
//   maze_in             memory read data, valid the cycle after maze_oe
// -----------------------------------------------------------------------------
module maze_port_arbiter #(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS*ADDR_W-1:0] req_row,
    input  logic [NPORTS*ADDR_W-1:0] req_col,
    input  logic [NPORTS-1:0]        req_oe,
    input  logic [NPORTS-1:0]        req_we,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        rvalid,
    output logic                     rdata,
    output logic [ADDR_W-1:0]        row,
    output logic [ADDR_W-1:0]        col,
    output logic                     maze_oe,
    output logic                     maze_we,
    input  logic                     maze_in
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    // Round-robin pointer: index of the most recent winner.
    logic [IDX_W-1:0]  last;

    // Pending read: loaded together with maze_oe, turned into rvalid the
    // cycle after.
    logic              pend_valid;
    logic [IDX_W-1:0]  pend_idx;

    logic [NPORTS-1:0] eligible;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic [ADDR_W-1:0] win_row;
    logic [ADDR_W-1:0] win_col;
    logic              win_oe;
    logic              win_we;

    // gnt is the registered grant of the current cycle, so masking with it
    // keeps a port out of the evaluation made at the end of its grant cycle.
    assign eligible = req & ~gnt;

    // Search last+1, last+2, ... modulo NPORTS; first eligible port wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        cand      = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = IDX_W'((int'(last) + i) % NPORTS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's address and qualifiers.
    always_comb begin
        win_row = '0;
        win_col = '0;
        win_oe  = 1'b0;
        win_we  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_row = req_row[k*ADDR_W +: ADDR_W];
                win_col = req_col[k*ADDR_W +: ADDR_W];
                win_oe  = req_oe[k];
                win_we  = req_we[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= IDX_W'(NPORTS - 1);
            gnt        <= '0;
            rvalid     <= '0;
            row        <= '0;
            col        <= '0;
            maze_oe    <= 1'b0;
            maze_we    <= 1'b0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
        end else begin
            // Pulses default low; row/col hold when nothing is granted.
            gnt        <= '0;
            maze_oe    <= 1'b0;
            maze_we    <= 1'b0;
            pend_valid <= 1'b0;

            rvalid <= '0;
            if (pend_valid) begin
                rvalid[pend_idx] <= 1'b1;
            end

            if (win_found) begin
                last         <= win_idx;
                gnt[win_idx] <= 1'b1;
                row          <= win_row;
                col          <= win_col;
                // Write has priority; a grant with neither qualifier is a no-op.
                maze_we      <= win_we;
                maze_oe      <= win_oe & ~win_we;
                pend_valid   <= win_oe & ~win_we;
                pend_idx     <= win_idx;
            end
        end
    end

    // Memory data is already aligned with rvalid.
    assign rdata = maze_in;

endmodule
